// File: rtl/note_sequencer.sv
// note_sequencer: turns note/play/stop key presses into load and playback controls for the note datapath.
// Latency: state and strobes change one clk after a key rising edge; each played note lasts BEAT_CYCLES cycles.
// Backpressure: none; keys are level inputs, only rising edges act, and the datapath must accept strobes every cycle.
module note_sequencer #(
  parameter int BEAT_CYCLES = 12500000,
  parameter int NUM_SLOTS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       note_key,
  input  logic       play_key,
  input  logic       stop_key,
  input  logic       loop_en,
  output logic       ld_note,
  output logic       ld_play,
  output logic [3:0] note_counter,
  output logic       next_note_en,
  output logic       display_note,
  output logic       playing,
  output logic [4:0] notes_stored
);

  localparam int             BW        = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BW-1:0]  BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [4:0]     SLOTS     = 5'(NUM_SLOTS);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_LOAD_DONE = 2'd2;
  localparam logic [1:0] S_PLAY      = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [4:0]    stored_q, stored_d;
  logic [3:0]    note_q, note_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          prev_note_q, prev_play_q, prev_stop_q;

  logic press_note, press_play, press_stop;
  logic last_note;

  // Rising-edge detect; a key held through reset release counts as a press.
  assign press_note = note_key & ~prev_note_q;
  assign press_play = play_key & ~prev_play_q;
  assign press_stop = stop_key & ~prev_stop_q;

  // The slot being played is the highest stored one.
  assign last_note = ({1'b0, note_q} + 5'd1) >= stored_q;

  // Next-state logic; presses resolve stop over play over note.
  always_comb begin
    state_d  = state_q;
    stored_d = stored_q;
    note_d   = note_q;
    beat_d   = beat_q;
    case (state_q)
      S_IDLE: begin
        if (press_stop) begin
          state_d = S_IDLE;
        end else if (press_play && (stored_q != 5'd0)) begin
          state_d = S_PLAY;
          note_d  = 4'd0;
          beat_d  = '0;
        end else if (press_note && (stored_q < SLOTS)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!note_key) begin
          state_d = S_LOAD_DONE;
        end
      end
      S_LOAD_DONE: begin
        // Gap cycle: the datapath advances its write address here.
        state_d = S_IDLE;
        if (stored_q < SLOTS) begin
          stored_d = stored_q + 5'd1;
        end
      end
      S_PLAY: begin
        if (press_stop) begin
          state_d = S_IDLE;
          note_d  = 4'd0;
          beat_d  = '0;
        end else if (press_play) begin
          note_d = 4'd0;
          beat_d = '0;
        end else if (beat_q == BEAT_LAST) begin
          beat_d = '0;
          if (!last_note) begin
            note_d = note_q + 4'd1;
          end else if (loop_en) begin
            note_d = 4'd0;
          end else begin
            // Natural end: note_counter keeps the last slot played.
            state_d = S_IDLE;
          end
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and key history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      stored_q    <= 5'd0;
      note_q      <= 4'd0;
      beat_q      <= '0;
      prev_note_q <= 1'b0;
      prev_play_q <= 1'b0;
      prev_stop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stored_q    <= stored_d;
      note_q      <= note_d;
      beat_q      <= beat_d;
      prev_note_q <= note_key;
      prev_play_q <= play_key;
      prev_stop_q <= stop_key;
    end
  end

  // Outputs decode registered state only, so an async reset clears them at once.
  assign ld_note      = (state_q == S_LOAD);
  assign display_note = ld_note;
  assign ld_play      = (state_q == S_PLAY);
  assign playing      = ld_play;
  assign next_note_en = (state_q == S_PLAY) && (beat_q == '0);
  assign note_counter = note_q;
  assign notes_stored = stored_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer with a 4-cycle beat: a timeline model of loading and playback
// checked every cycle, plus hand-computed literal expectations for each scenario.
module tb_note_sequencer;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       note_key = 1'b0, play_key = 1'b0, stop_key = 1'b0, loop_en = 1'b0;
  logic       ld_note, ld_play, next_note_en, display_note, playing;
  logic [3:0] note_counter;
  logic [4:0] notes_stored;

  int checks = 0;
  int failures = 0;

  note_sequencer #(.BEAT_CYCLES(B), .NUM_SLOTS(16)) dut (
    .clk(clk), .reset(reset), .note_key(note_key), .play_key(play_key),
    .stop_key(stop_key), .loop_en(loop_en), .ld_note(ld_note), .ld_play(ld_play),
    .note_counter(note_counter), .next_note_en(next_note_en),
    .display_note(display_note), .playing(playing), .notes_stored(notes_stored)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode plus elapsed playback time t; the note is t/B and a pulse when t%B==0.
  localparam int M_IDLE = 0, M_LOAD = 1, M_GAP = 2, M_PLAY = 3;
  int m_mode = M_IDLE, m_stored = 0, m_t = 0, m_hold = 0;
  bit m_pn = 0, m_pp = 0, m_ps = 0;

  always @(posedge clk or negedge reset) begin
    bit pn, pp, ps;
    if (!reset) begin
      m_mode = M_IDLE; m_stored = 0; m_t = 0; m_hold = 0;
      m_pn = 0; m_pp = 0; m_ps = 0;
    end else begin
      pn = note_key && !m_pn;
      pp = play_key && !m_pp;
      ps = stop_key && !m_ps;
      case (m_mode)
        M_IDLE: begin
          if (ps) m_mode = M_IDLE;
          else if (pp && m_stored > 0) begin m_mode = M_PLAY; m_t = 0; end
          else if (pn && m_stored < 16) m_mode = M_LOAD;
        end
        M_LOAD: if (!note_key) m_mode = M_GAP;
        M_GAP: begin
          if (m_stored < 16) m_stored = m_stored + 1;
          m_mode = M_IDLE;
        end
        default: begin
          if (ps) begin m_mode = M_IDLE; m_hold = 0; end
          else if (pp) m_t = 0;
          else begin
            m_t = m_t + 1;
            if (m_t == m_stored * B) begin
              if (loop_en) m_t = 0;
              else begin m_mode = M_IDLE; m_hold = m_stored - 1; end
            end
          end
        end
      endcase
      m_pn = note_key; m_pp = play_key; m_ps = stop_key;
    end
  end

  // Every out-of-reset cycle, compare all outputs against the model.
  always @(negedge clk) begin
    if (reset) begin
      check("m_ld_note", 32'(ld_note), 32'(m_mode == M_LOAD));
      check("m_display_note", 32'(display_note), 32'(m_mode == M_LOAD));
      check("m_ld_play", 32'(ld_play), 32'(m_mode == M_PLAY));
      check("m_playing", 32'(playing), 32'(m_mode == M_PLAY));
      check("m_next_note_en", 32'(next_note_en), 32'(m_mode == M_PLAY && (m_t % B) == 0));
      check("m_note_counter", 32'(note_counter), (m_mode == M_PLAY) ? 32'(m_t / B) : 32'(m_hold));
      check("m_notes_stored", 32'(notes_stored), 32'(m_stored));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold note_key for len cycles, then count ld_note cycles and check the gap and count.
  task automatic load_note(input int len, input int exp_cnt, input int exp_stored);
    int cnt;
    cnt = 0;
    note_key = 1'b1;
    for (int k = 0; k < len + 4; k++) begin
      @(negedge clk);
      if (ld_note === 1'b1) cnt++;
      if (k == len + 1) check("load_gap_cycle", 32'(ld_note), 32'd0);
      tick();
      if (k == len - 1) note_key = 1'b0;
    end
    check("load_ld_note_cycles", 32'(cnt), 32'(exp_cnt));
    check("load_notes_stored", 32'(notes_stored), 32'(exp_stored));
  endtask

  initial begin
    int seq [5];
    int pulses;

    // 1. reset held, then idle; play with nothing stored is ignored
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", 32'({ld_note, ld_play, next_note_en, display_note, playing}), 32'd0);
      check("reset_counts", 32'({note_counter, notes_stored}), 32'd0);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("idle_notes_stored", 32'(notes_stored), 32'd0);
    check("idle_ld_play", 32'(ld_play), 32'd0);
    tick();
    play_key = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("empty_play_ignored", 32'(ld_play), 32'd0);
      tick();
    end
    play_key = 1'b0;
    tick();

    // 2. load three notes
    for (int i = 1; i <= 3; i++) load_note(5, 5, i);

    // 3. play without loop: notes 0,1,2 of 4 cycles, pulses at 1,5,9, ld_play off at 13
    loop_en = 1'b0;
    play_key = 1'b1;
    tick();
    play_key = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("play_ld_play", 32'(ld_play), 32'(k <= 12));
      check("play_pulse", 32'(next_note_en), 32'(k == 1 || k == 5 || k == 9));
      if (k <= 12) check("play_note", 32'(note_counter), 32'((k - 1) / 4));
      else check("play_note_hold", 32'(note_counter), 32'd2);
      tick();
    end

    // 4. loop then stop mid-note
    loop_en = 1'b1;
    play_key = 1'b1;
    tick();
    play_key = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k % 4 == 1 && k <= 17) seq[(k - 1) / 4] = note_counter;
      if (k >= 19 && next_note_en === 1'b1) pulses++;
      if (k == 19) begin
        check("stop_ld_play", 32'(ld_play), 32'd0);
        check("stop_note_zero", 32'(note_counter), 32'd0);
      end
      tick();
      if (k == 17) stop_key = 1'b1;
      if (k == 18) stop_key = 1'b0;
    end
    check("loop_seq", 32'({seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0], seq[4][3:0]}),
          32'h01201);
    check("stop_no_pulses", 32'(pulses), 32'd0);

    // 5a. play and note pressed together: play wins
    loop_en = 1'b0;
    play_key = 1'b1;
    note_key = 1'b1;
    tick();
    @(negedge clk);
    check("prio_ld_play", 32'(ld_play), 32'd1);
    check("prio_ld_note", 32'(ld_note), 32'd0);
    tick();
    play_key = 1'b0;
    stop_key = 1'b1;
    tick();
    stop_key = 1'b0;
    note_key = 1'b0;
    tick();
    @(negedge clk);
    check("prio_stopped", 32'({ld_play, ld_note}), 32'd0);
    tick();

    // 5b. fill memory to 16, then a 17th press is ignored
    for (int i = 4; i <= 16; i++) load_note(2, 2, i);
    load_note(2, 0, 16);

    // 6. async reset between edges during playback
    loop_en = 1'b1;
    play_key = 1'b1;
    tick();
    play_key = 1'b0;
    repeat (6) tick();
    check("pre_reset_ld_play", 32'(ld_play), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_ld_play", 32'(ld_play), 32'd0);
    check("async_next_note_en", 32'(next_note_en), 32'd0);
    check("async_notes_stored", 32'(notes_stored), 32'd0);
    check("async_rest", 32'({ld_note, playing, display_note, note_counter}), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("post_reset_idle", 32'({ld_play, notes_stored}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
